mem_arbiter: RTL
================

# mem_arbiter

Parametrised N-channel memory arbiter. It lets several pipeline requesters (fetcher, accessor, and any future DMA or debug port) share the single core memory port. Requests are granted by fixed priority or round-robin, and one transaction is held on the memory port at a time. A bus-timeout check returns an error instead of hanging the pipeline.

## Interface
Parameters:
- CHANNELS, 2: number of requesters; legal range 1..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; must be a multiple of 8. STRB_W = DATA_W/8.
- RR, 1: arbitration mode. 1 = round-robin, 0 = fixed priority (lowest index wins).
- TIMEOUT, 16: maximum BUSY cycles spent waiting for mem_valid. 0 disables the timeout.

Ports (clock and reset first). Channel buses are flattened; channel i occupies slice [i*W +: W].
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- req_ready  in  CHANNELS  per-channel request. Held high until that channel's req_valid pulse.
- req_addr  in  CHANNELS*ADDR_W  per-channel address. Stable while request is pending.
- req_wdata  in  CHANNELS*DATA_W  per-channel write data. Stable while request is pending.
- req_wstrb  in  CHANNELS*STRB_W  per-channel byte strobes; 0 means read.
- req_valid  out  CHANNELS  one-cycle completion pulse, one-hot.
- req_err  out  1  qualifies req_valid; 1 = the transaction timed out.
- req_rdata  out  DATA_W  read data, valid in the req_valid cycle; shared by all channels.
- grant  out  max(1,$clog2(CHANNELS))  index of the current or last owner.
- mem_ready  out  1  memory request strobe.
- mem_addr  out  ADDR_W  address driven to memory.
- mem_wdata  out  DATA_W  write data driven to memory.
- mem_wstrb  out  STRB_W  byte strobes driven to memory.
- mem_valid  in  1  memory completion; only sampled while mem_ready=1.
- mem_rdata  in  DATA_W  memory read data, sampled with mem_valid.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req_ready bit is set, select a winner, register grant, latch that channel's addr/wdata/wstrb into the mem_* registers, set mem_ready=1, and go to BUSY.
  - Otherwise stay in IDLE with mem_ready=0.
- BUSY: mem_ready=1, and mem_addr/mem_wdata/mem_wstrb are held constant.
  - On mem_valid=1: capture mem_rdata into req_rdata, clear mem_ready, set req_err=0, go to RESP.
  - On timeout (count reaches TIMEOUT-1 with no mem_valid): clear mem_ready, set req_err=1, leave req_rdata unchanged, go to RESP.
- RESP: req_valid[grant]=1 for exactly this cycle, then go to IDLE.
  - RESP exists so the requester can drop req_ready before the next IDLE evaluation, which prevents a double grant.
- Fixed priority: the lowest set index wins.
- Round-robin: search starts at last_grant+1 mod CHANNELS and wraps. last_grant updates only on entry to BUSY.
- CHANNELS=1: grant is constantly 0 and arbitration is trivial.
- mem_valid is ignored in IDLE and RESP.
- A mem_valid arriving in the same cycle the timeout expires counts as a success (req_err=0).
- A requester dropping req_ready while its request is in BUSY is a protocol violation. The transaction completes anyway and req_valid still pulses.
- Reset:
  - Forces IDLE. Clears mem_ready, req_valid, req_err and the timeout counter.
  - grant=0, last_grant=CHANNELS-1 so channel 0 wins first. mem_addr/mem_wdata/mem_wstrb/req_rdata=0.
  - A reset mid-transaction abandons that transaction; no req_valid is produced for it.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Minimum transaction timeline, with T = first cycle req_ready is seen in IDLE:
  - T+1: mem_ready=1 and mem_* valid.
  - mem_valid arrives at cycle M ≥ T+1.
  - M+1: req_valid pulse with req_rdata.
  - M+2: IDLE, arbitration resumes.
- Best-case occupancy is 3 cycles per transaction (M=T+1). Back-to-back grants are separated by at least one mem_ready=0 cycle.
- Timeout: with TIMEOUT=N, mem_ready stays high for exactly N cycles. req_valid with req_err=1 follows on the next cycle.
- Worst-case wait for a continuously requesting channel, round-robin mode: CHANNELS-1 other transactions.

## Test plan
- Single read: ch0 requests addr 0x100, wstrb 0, and memory returns 0xDEADBEEF 2 cycles after mem_ready. Expect:
  - mem_addr=0x100 on the cycle after the request.
  - req_valid=2'b01 and req_rdata=0xDEADBEEF one cycle after mem_valid, with req_err=0.
- Contention, RR=1, CHANNELS=2: both channels request continuously for 4 transactions. Expect:
  - grant sequence 0,1,0,1.
  - mem_ready low for at least one cycle between grants.
  - No channel receives two req_valid pulses for one request.
- Contention, RR=0: same stimulus. Expect grant 0 while ch0 keeps requesting; ch1 is granted only once ch0 is idle.
- Write: ch1 requests addr 0x20, wdata 0x12345678, wstrb 4'b0011. Expect:
  - mem_wstrb=4'b0011 and mem_wdata=0x12345678, held constant through BUSY.
  - req_valid[1] pulses after mem_valid.
- Timeout, TIMEOUT=4, mem_valid held at 0. Expect mem_ready high for exactly 4 cycles, then req_valid[0]=1 with req_err=1. A late mem_valid arriving after that is ignored.
- Reset mid-BUSY: assert reset for 1 cycle while mem_ready=1. Expect:
  - On the next cycle: mem_ready=0, req_valid=0, grant=0, FSM in IDLE.
  - If requests are still held, a fresh grant of channel 0 on the following cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_arbiter.
// Channel buses are flattened; channel i occupies slice [i*W +: W].
interface mem_arbiter_if #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int GRANT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]        req_ready;
    logic [CHANNELS*ADDR_W-1:0] req_addr;
    logic [CHANNELS*DATA_W-1:0] req_wdata;
    logic [CHANNELS*STRB_W-1:0] req_wstrb;
    logic [CHANNELS-1:0]        req_valid;
    logic                       req_err;
    logic [DATA_W-1:0]          req_rdata;
    logic [GRANT_W-1:0]         grant;

    logic                       mem_ready;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic [STRB_W-1:0]          mem_wstrb;
    logic                       mem_valid;
    logic [DATA_W-1:0]          mem_rdata;

    // Arbiter view
    modport slave (
        input  req_ready, req_addr, req_wdata, req_wstrb, mem_valid, mem_rdata,
        output req_valid, req_err, req_rdata, grant,
               mem_ready, mem_addr, mem_wdata, mem_wstrb
    );

    // Requesters plus memory model view
    modport master (
        output req_ready, req_addr, req_wdata, req_wstrb, mem_valid, mem_rdata,
        input  req_valid, req_err, req_rdata, grant,
               mem_ready, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel arbiter sharing one memory port: fixed-priority or round-robin grant,
// one outstanding transaction, bus timeout reported through req_err.
module mem_arbiter #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RR       = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int GRANT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [CHANNELS-1:0][ADDR_W-1:0] ch_addr;
    logic [CHANNELS-1:0][DATA_W-1:0] ch_wdata;
    logic [CHANNELS-1:0][STRB_W-1:0] ch_wstrb;

    assign ch_addr  = bus.req_addr;
    assign ch_wdata = bus.req_wdata;
    assign ch_wstrb = bus.req_wstrb;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [GRANT_W-1:0]  grant, last_grant;
    logic [CHANNELS-1:0] req_valid;
    logic                req_err;
    logic [DATA_W-1:0]   req_rdata;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [STRB_W-1:0]   mem_wstrb;

    // Winner select. lo_win is the lowest requester overall; hi_win is the lowest
    // requester above last_grant, which gives the wrapping round-robin search.
    logic [GRANT_W-1:0] lo_win, hi_win, win;
    logic               hi_found;

    always_comb begin
        lo_win   = '0;
        hi_win   = '0;
        hi_found = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.req_ready[i]) begin
                lo_win = GRANT_W'(i);
                if (i > int'(last_grant)) begin
                    hi_win   = GRANT_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        if (CHANNELS == 1)
            win = '0;
        else if (RR != 0 && hi_found)
            win = hi_win;
        else
            win = lo_win;
    end

    logic [CHANNELS-1:0] grant_oh;
    assign grant_oh = CHANNELS'(1) << grant;

    logic timed_out;
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= '0;
            last_grant <= GRANT_W'(CHANNELS - 1);
            req_valid  <= '0;
            req_err    <= 1'b0;
            req_rdata  <= '0;
            mem_ready  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            req_valid <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req_ready) begin
                        grant      <= win;
                        last_grant <= win;
                        mem_addr   <= ch_addr[win];
                        mem_wdata  <= ch_wdata[win];
                        mem_wstrb  <= ch_wstrb[win];
                        mem_ready  <= 1'b1;
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // mem_valid wins over a simultaneous timeout expiry
                    if (bus.mem_valid) begin
                        req_rdata <= bus.mem_rdata;
                        req_err   <= 1'b0;
                        req_valid <= grant_oh;
                        mem_ready <= 1'b0;
                        state     <= RESP;
                    end else if (timed_out) begin
                        req_err   <= 1'b1;
                        req_valid <= grant_oh;
                        mem_ready <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant;
    assign bus.req_valid = req_valid;
    assign bus.req_err   = req_err;
    assign bus.req_rdata = req_rdata;
    assign bus.mem_ready = mem_ready;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_wstrb = mem_wstrb;
endmodule
